cordic_seq_ctrl: RTL and testbench

CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_var_shifter.sv | 15 +
 rtl/cordic_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_cordic_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the sequential CORDIC rotator.
//   state_e   : controller states (idle / iterating / result held)
//   DefW      : default data and angle width
//   DefIter   : default number of micro-rotations per operation
//   atan_lut  : arctangent of 2^-i, angle LSB = pi/16 rad
package cordic_pkg;

  localparam int unsigned DefW    = 4;
  localparam int unsigned DefIter = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // atan(2^-i) rounded to pi/16 units: 45, 26.6, 14.0, 7.1 degrees.
  function automatic logic [7:0] atan_lut(input logic [1:0] idx);
    logic [7:0] val;
    unique case (idx)
      2'd0:    val = 8'd4;
      2'd1:    val = 8'd2;
      2'd2:    val = 8'd1;
      default: val = 8'd1;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_var_shifter.sv
// Variable arithmetic right shift (sign fill).
//   data_i  : W-bit two's-complement operand
//   shamt_i : shift amount 0..3
//   data_o  : data_i >>> shamt_i
module cordic_var_shifter #(
  parameter int unsigned W = 4
) (
  input  logic signed [W-1:0] data_i,
  input  logic        [1:0]   shamt_i,
  output logic signed [W-1:0] data_o
);

  assign data_o = data_i >>> shamt_i;

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Sequential rotation-mode CORDIC: one micro-rotation per clock.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only when idle)
//   X_in, Y_in, Z_in      : start vector and angle (angle LSB = pi/16 rad)
//   out_valid / out_ready : result handshake (valid only when done)
//   X_out, Y_out, Z_out   : working registers, meaningful while out_valid
//   busy                  : operation in progress or result pending
//   iter_idx              : current shift amount
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned W    = DefW,
  parameter int unsigned ITER = DefIter
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X_in,
  input  logic [W-1:0] Y_in,
  input  logic [W-1:0] Z_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] X_out,
  output logic [W-1:0] Y_out,
  output logic [W-1:0] Z_out,
  output logic         busy,
  output logic [1:0]   iter_idx
);

  localparam logic [1:0] IterLast = 2'(ITER - 1);

  state_e state_q, state_d;
  logic [1:0] iter_q, iter_d;
  logic signed [W-1:0] x_q, x_d;
  logic signed [W-1:0] y_q, y_d;
  logic signed [W-1:0] z_q, z_d;

  logic signed [W-1:0] x_sh, y_sh;
  logic signed [W-1:0] atan_w;
  logic                rot_pos;

  cordic_var_shifter #(
    .W(W)
  ) u_shift_x (
    .data_i (x_q),
    .shamt_i(iter_q),
    .data_o (x_sh)
  );

  cordic_var_shifter #(
    .W(W)
  ) u_shift_y (
    .data_i (y_q),
    .shamt_i(iter_q),
    .data_o (y_sh)
  );

  assign atan_w  = W'(atan_lut(iter_q));
  // Rotate counter-clockwise while the residual angle is non-negative.
  assign rot_pos = ~z_q[W-1];

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = X_in;
          y_d     = Y_in;
          z_d     = Z_in;
          iter_d  = 2'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (rot_pos) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_w;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_w;
        end
        iter_d = iter_q + 2'd1;
        if (iter_q == IterLast) begin
          iter_d  = 2'd0;
          state_d = StDone;
        end
      end
      StDone: begin
        // Always return through idle so a new accept never shares the result edge.
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        iter_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      iter_q  <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign iter_idx  = iter_q;
  assign X_out     = x_q;
  assign Y_out     = y_q;
  assign Z_out     = z_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Scoreboard bench for cordic_seq_ctrl: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on each result handshake.
module tb_cordic_seq_ctrl;

  localparam int unsigned W    = 4;
  localparam int unsigned ITER = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] X_in, Y_in, Z_in, X_out, Y_out, Z_out;
  logic [1:0]   iter_idx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } res_t;

  res_t exp_q[$];
  int   acc_q[$];     // accept edges still waiting for out_valid
  int   acc_hist[$];  // every accept edge seen

  cordic_seq_ctrl #(
    .W   (W),
    .ITER(ITER)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X_in     (X_in),
    .Y_in     (Y_in),
    .Z_in     (Z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .X_out    (X_out),
    .Y_out    (Y_out),
    .Z_out    (Z_out),
    .busy     (busy),
    .iter_idx (iter_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: records accepts, checks latency and compares results at handshake.
  initial begin : monitor
    bit   prev_valid;
    int   a;
    res_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          acc_q.push_back(cyc + 1);
          acc_hist.push_back(cyc + 1);
        end
        if (out_valid && !prev_valid) begin
          if (acc_q.size() == 0) check("unexpected_out_valid", 1, 0);
          else begin
            a = acc_q.pop_front();
            check("latency", cyc - a, ITER);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_result", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("X_out", X_out, e.x);
            check("Y_out", Y_out, e.y);
            check("Z_out", Z_out, e.z);
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] ex, input logic [W-1:0] ey,
                          input logic [W-1:0] ez);
    res_t r;
    r.x = ex;
    r.y = ey;
    r.z = ez;
    exp_q.push_back(r);
  endtask

  // Present operands until accepted; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                       input logic [W-1:0] ex, input logic [W-1:0] ey,
                       input logic [W-1:0] ez);
    bit done;
    push_exp(ex, ey, ez);
    X_in     = x;
    Y_in     = y;
    Z_in     = z;
    in_valid = 1'b1;
    done     = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    if (!done) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (!busy && !out_valid) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    X_in      = '0;
    Y_in      = '0;
    Z_in      = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_iter_idx", iter_idx, 0);
    check("rst_X_out", X_out, 0);
    check("rst_Y_out", Y_out, 0);
    check("rst_Z_out", Z_out, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic rotation of (4,0) by 0.
    issue(4'd4, 4'd0, 4'd0, 4'd6, 4'd1, 4'd0);
    wait_idle();

    // (3,0) by pi/4, tracing the shift index.
    issue(4'd3, 4'd0, 4'd4, 4'd3, 4'd4, 4'd0);
    for (int k = 0; k < ITER; k++) begin
      check("run_iter_idx", iter_idx, k);
      check("run_busy", busy, 1);
      tick();
    end
    check("done_out_valid", out_valid, 1);
    wait_idle();

    // Wrapping case.
    issue(4'd7, 4'd7, 4'd0, 4'hD, 4'd0, 4'd0);
    wait_idle();

    // Hold the result with out_ready low while in_valid is pulsed.
    out_ready = 1'b0;
    issue(4'd4, 4'd0, 4'd0, 4'd6, 4'd1, 4'd0);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("hold_reached_done", out_valid, 1);
    base = acc_hist.size();
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      X_in     = 4'd1;
      Y_in     = 4'd2;
      Z_in     = 4'd3;
      tick();
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_X_out", X_out, 4'd6);
      check("hold_Y_out", Y_out, 4'd1);
      check("hold_Z_out", Z_out, 4'd0);
    end
    check("hold_no_accept", acc_hist.size(), base);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);

    // Reset in the middle of an operation.
    issue(4'd3, 4'd0, 4'd4, 4'd3, 4'd4, 4'd0);
    tick();
    tick();
    check("pre_rst_iter_idx", iter_idx, 2);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    acc_q.delete();
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_iter_idx", iter_idx, 0);
    check("mid_rst_X_out", X_out, 0);
    check("mid_rst_Y_out", Y_out, 0);
    check("mid_rst_Z_out", Z_out, 0);
    tick();
    rst = 1'b0;
    tick();
    issue(4'd4, 4'd0, 4'd0, 4'd6, 4'd1, 4'd0);
    wait_idle();

    // Back-to-back with in_valid held high.
    base = acc_hist.size();
    for (int i = 0; i < 3; i++) push_exp(4'd6, 4'd1, 4'd0);
    X_in     = 4'd4;
    Y_in     = 4'd0;
    Z_in     = 4'd0;
    in_valid = 1'b1;
    n        = 0;
    while (acc_hist.size() < base + 3 && n < 60) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", acc_hist.size(), base + 3);
    if (acc_hist.size() >= base + 3) begin
      check("b2b_gap0", acc_hist[base + 1] - acc_hist[base], ITER + 2);
      check("b2b_gap1", acc_hist[base + 2] - acc_hist[base + 1], ITER + 2);
    end
    wait_idle();
    tick();
    check("results_outstanding", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
